debug_host: RTL
===============

# debug_host

Host-side master for the UART debug byte protocol, the initiating end of the debug requester. It accepts word-granular read/write commands on a simple valid/ready port and serialises them as protocol frames onto a TX byte stream. For reads, it reassembles the returned bytes into 32-bit words. It sits between an on-chip controller (e.g. a board-management CPU or boot loader) and a UART, and drives a remote FPGA's debug requester.

## Interface
- TX_FIFO_LOG2, 3, log2 depth of the internal TX byte FIFO
- RX_FIFO_LOG2, 3, log2 depth of the internal RX byte FIFO
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_RnW  in  1  1 = read, 0 = write
- cmd_len  in  8  length in 32-bit words (1..255)
- cmd_address  in  32  byte address; bits [1:0] are sent as zero
- wr_data  in  32  write word
- wr_data_valid  in  1  write word offered
- wr_data_ready  out  1  write word taken when high with wr_data_valid
- rd_data  out  32  read word, little-endian assembled
- rd_data_valid  out  1  read word presented
- rd_data_ready  in  1  consumer takes rd_data
- cmd_done  out  1  one-cycle pulse at command completion
- cmd_err  out  1  valid with cmd_done: length 0, or bad ack
- tx_data  out  8  TX FIFO head byte
- tx_has_data  out  1  TX FIFO non-empty
- tx_data_consume  in  1  pop TX FIFO
- rx_data  in  8  received byte
- rx_has_space  out  1  RX FIFO can accept
- rx_data_produce  in  1  push rx_data

## Operation
- Frame format:
  - byte 0: command (0x01 = write, 0x02 = read, 0x03 = write with ack)
  - byte 1: cmd_len
  - bytes 2–5: address, little-endian
  - then, for writes, cmd_len×4 data bytes, little-endian
- Reads return cmd_len×4 bytes, little-endian. Write-with-ack returns the single byte 0xaa.
- States: IDLE, HDR, WDATA, WACK, RDATA, RPUSH, DONE.
- IDLE:
  - cmd_ready=1.
  - Any RX bytes are stray: popped and discarded.
  - On handshake, latch RnW, len and address. If len==0, go to DONE with err=1 and send nothing; otherwise go to HDR with byte index 0.
- HDR: emit one header byte per cycle while the TX FIFO has space. After byte 5, go to RDATA (read) or WDATA (write).
- WDATA:
  - wr_data_ready=1 only when byte index==0 and the TX FIFO has space. The handshake latches the word into a shift register.
  - Emit bytes 0..3 of the word, one per cycle with TX space.
  - Decrement the word count after byte 3. At 0, go to WACK if the ack is enabled, else DONE.
- WACK: wait for one RX byte and pop it. 0xaa → DONE with err=0; any other value → DONE with err=1.
- RDATA: pop RX bytes into the word, LE (first byte → [7:0]). After the 4th byte go to RPUSH.
- RPUSH:
  - rd_data_valid=1, with rd_data stable until rd_data_ready.
  - No RX pops while in RPUSH.
  - Decrement the word count; go back to RDATA if non-zero, else DONE.
- DONE: cmd_done=1 for one cycle, cmd_err as determined, then IDLE.
- Word counter is 8 bits. Byte index is 2 bits and wraps 3→0.
- No timeout: a missing remote response stalls in RDATA/WACK until reset.

## Timing
- Reset values: cmd_ready=0, wr_data_ready=0, rd_data_valid=0, rd_data=0, cmd_done=0, cmd_err=0, tx_has_data=0, rx_has_space=0. Both FIFOs are flushed.
- Reset may arrive mid-frame. The block returns to IDLE, and any partial frame is abandoned (the remote must be resynchronised by software).
- First header byte is visible on tx_data 2 cycles after the cmd handshake: handshake cycle, then HDR enqueue, then FIFO output.
- Throughput: at most one TX enqueue and one RX pop per cycle.
- TX full stalls HDR/WDATA with no byte lost or duplicated. RX empty stalls RDATA/WACK.
- cmd_ready is low from acceptance through the DONE cycle. Back-to-back commands are possible with one idle cycle.
- rd_data_valid rises the cycle after the 4th byte is popped.
- Simultaneous rx_data_produce and pop on the same FIFO are both honoured.

## Configuration
- DEBUG_HOST_WR_ACK_EN defined:
  - writes use command 0x03 and pass through WACK;
  - cmd_done is asserted only after 0xaa arrives (barrier semantic).
- Undefined:
  - writes use 0x01;
  - WACK is unreachable;
  - cmd_done is asserted once the last data byte has entered the TX FIFO;
  - cmd_err for writes reflects len==0 only.

## Structure
- Shared package: command byte constants (0x01/0x02/0x03), ack byte 0xaa, state encodings, header length 6.
- Sub-module: two instances of the existing simple_fifo (DWIDTH=8), one for RX and one for TX.
- Everything else is a single always block FSM plus a small combinational output decode.

## Test plan
- Read len=1 @0x00001004 → TX bytes 02 01 04 10 00 00. Inject 78 56 34 12 → rd_data=0x12345678, then cmd_done with err=0.
- Write len=2 @0x20, words 0xAABBCCDD, 0x11223344 (ack disabled) → TX bytes 01 02 20 00 00 00 DD CC BB AA 44 33 22 11, then cmd_done.
- DEBUG_HOST_WR_ACK_EN, write len=1 → first byte 03. Inject 0xaa → done with err=0. Repeat with 0x55 → done with err=1.
- len=0 command → no TX bytes, cmd_done with cmd_err=1 one cycle after acceptance.
- Backpressure: hold tx_data_consume low so the TX FIFO fills, and hold rd_data_ready low for 10 cycles during a len=3 read → byte order is intact, each word is delivered exactly once, and stray RX bytes sent before the command are discarded.
- Assert reset mid-HDR → all outputs at their reset values. The next read completes normally.

Source files
------------

// File: rtl/debug_host_pkg.sv
// debug_host_pkg: constants and types shared by the debug host block.
//   - Command bytes used in byte 0 of a frame, and the write-ack byte.
//   - Header length and FSM state encoding.
//   - hdr_byte(): selects one byte of the 6-byte frame header.
package debug_host_pkg;

  localparam logic [7:0] CmdWrite = 8'h01;
  localparam logic [7:0] CmdRead  = 8'h02;
  localparam logic [7:0] CmdWrAck = 8'h03;
  localparam logic [7:0] AckByte  = 8'haa;

  localparam int unsigned HdrLen = 6;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWdata,
    StWack,
    StRdata,
    StRpush,
    StDone
  } state_e;

  // Header layout: command, length, then the address little-endian.
  function automatic logic [7:0] hdr_byte(input logic [7:0]  cmd,
                                          input logic [7:0]  len,
                                          input logic [31:0] addr,
                                          input logic [2:0]  idx);
    case (idx)
      3'd0:    return cmd;
      3'd1:    return len;
      3'd2:    return addr[7:0];
      3'd3:    return addr[15:8];
      3'd4:    return addr[23:16];
      3'd5:    return addr[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/debug_host_if.sv
// debug_host_if: command, write-data, read-data, completion and UART byte-stream
// signals of the debug host.
//   master: the controller/UART side (drives commands, write words, RX bytes,
//           TX pops and read-data acceptance).
//   slave:  the debug host itself.
interface debug_host_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_RnW;
  logic [7:0]  cmd_len;
  logic [31:0] cmd_address;

  logic [31:0] wr_data;
  logic        wr_data_valid;
  logic        wr_data_ready;

  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_data_ready;

  logic        cmd_done;
  logic        cmd_err;

  logic [7:0]  tx_data;
  logic        tx_has_data;
  logic        tx_data_consume;

  logic [7:0]  rx_data;
  logic        rx_has_space;
  logic        rx_data_produce;

  modport master (
    output cmd_valid, cmd_RnW, cmd_len, cmd_address,
    output wr_data, wr_data_valid, rd_data_ready,
    output tx_data_consume, rx_data, rx_data_produce,
    input  cmd_ready, wr_data_ready, rd_data, rd_data_valid,
    input  cmd_done, cmd_err, tx_data, tx_has_data, rx_has_space
  );

  modport slave (
    input  cmd_valid, cmd_RnW, cmd_len, cmd_address,
    input  wr_data, wr_data_valid, rd_data_ready,
    input  tx_data_consume, rx_data, rx_data_produce,
    output cmd_ready, wr_data_ready, rd_data, rd_data_valid,
    output cmd_done, cmd_err, tx_data, tx_has_data, rx_has_space
  );

endinterface

// File: rtl/simple_fifo.sv
// simple_fifo: single-clock FIFO, 2**LOG2_DEPTH entries of DWIDTH bits.
//   clk, reset      clock, asynchronous active-high reset (flushes contents)
//   push, push_data write side; push ignored when has_space is low
//   pop, head       read side; head is the oldest entry, pop ignored when empty
//   has_data        FIFO non-empty
//   has_space       FIFO can accept a push (registered, low during reset)
module simple_fifo #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic              has_data,
  output logic              has_space
);

  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam int unsigned CntW  = LOG2_DEPTH + 1;

  logic [DWIDTH-1:0]     mem_q [Depth];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  space_q;
  logic                  do_push, do_pop;

  assign do_push = push && space_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      space_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      // Registered full flag keeps has_space low while in reset.
      space_q <= (count_d != CntW'(Depth));
      if (do_push) wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + LOG2_DEPTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head      = mem_q[rd_ptr_q];
  assign has_data  = (count_q != '0);
  assign has_space = space_q;

endmodule

// File: rtl/debug_host.sv
// debug_host: host-side master of the UART debug byte protocol.
// Turns word-granular read/write commands into frames on a TX byte stream and
// reassembles read responses from an RX byte stream into 32-bit words.
//   clk, reset  clock, asynchronous active-high reset (abandons any frame)
//   bus         debug_host_if.slave: command, write/read words, completion,
//               TX FIFO head/pop and RX FIFO push/space
// Build option: DEBUG_HOST_WR_ACK_EN makes writes use command 0x03 and wait for
// the 0xaa ack byte before signalling completion.
module debug_host
  import debug_host_pkg::*;
#(
  parameter int unsigned TX_FIFO_LOG2 = 3,
  parameter int unsigned RX_FIFO_LOG2 = 3
) (
  input logic         clk,
  input logic         reset,
  debug_host_if.slave bus
);

`ifdef DEBUG_HOST_WR_ACK_EN
  localparam logic       WrAckEn = 1'b1;
  localparam logic [7:0] WrCmd   = CmdWrAck;
`else
  localparam logic       WrAckEn = 1'b0;
  localparam logic [7:0] WrCmd   = CmdWrite;
`endif

  state_e      state_q;
  logic        cmd_ready_q;
  logic        rnw_q;
  logic [7:0]  len_q;
  logic [31:0] addr_q;
  logic [7:0]  cnt_q;
  logic [2:0]  hdr_idx_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;
  logic [31:0] rd_word_q;
  logic        err_q;

  logic        tx_push, tx_space, tx_avail;
  logic [7:0]  tx_byte, tx_head;
  logic        rx_pop, rx_avail, rx_space;
  logic [7:0]  rx_head;
  logic        wr_take;

  simple_fifo #(
    .DWIDTH    (8),
    .LOG2_DEPTH(TX_FIFO_LOG2)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_push),
    .push_data(tx_byte),
    .pop      (bus.tx_data_consume),
    .head     (tx_head),
    .has_data (tx_avail),
    .has_space(tx_space)
  );

  simple_fifo #(
    .DWIDTH    (8),
    .LOG2_DEPTH(RX_FIFO_LOG2)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.rx_data_produce),
    .push_data(bus.rx_data),
    .pop      (rx_pop),
    .head     (rx_head),
    .has_data (rx_avail),
    .has_space(rx_space)
  );

  // Byte 0 of a write word goes straight from wr_data in the handshake cycle;
  // bytes 1..3 come from the shift register.
  always_comb begin
    tx_push = 1'b0;
    tx_byte = 8'h00;
    rx_pop  = 1'b0;
    wr_take = 1'b0;
    unique case (state_q)
      StIdle: rx_pop = rx_avail;  // stray bytes are discarded
      StHdr: begin
        tx_push = tx_space;
        tx_byte = hdr_byte(rnw_q ? CmdRead : WrCmd, len_q, addr_q, hdr_idx_q);
      end
      StWdata: begin
        if (byte_idx_q == 2'd0) begin
          wr_take = tx_space;
          tx_push = tx_space && bus.wr_data_valid;
          tx_byte = bus.wr_data[7:0];
        end else begin
          tx_push = tx_space;
          tx_byte = shift_q[7:0];
        end
      end
      StWack, StRdata: rx_pop = rx_avail;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      rnw_q       <= 1'b0;
      len_q       <= 8'h00;
      addr_q      <= 32'h0;
      cnt_q       <= 8'h00;
      hdr_idx_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      shift_q     <= 24'h0;
      rd_word_q   <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            rnw_q       <= bus.cmd_RnW;
            len_q       <= bus.cmd_len;
            addr_q      <= bus.cmd_address & 32'hffff_fffc;
            cnt_q       <= bus.cmd_len;
            hdr_idx_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
            if (bus.cmd_len == 8'd0) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q   <= 1'b0;
              state_q <= StHdr;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StHdr: begin
          if (tx_push) begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
            if (hdr_idx_q == 3'(HdrLen - 1)) state_q <= rnw_q ? StRdata : StWdata;
          end
        end
        StWdata: begin
          if (tx_push) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd0) shift_q <= bus.wr_data[31:8];
            else                    shift_q <= {8'h00, shift_q[23:8]};
            if (byte_idx_q == 2'd3) begin
              cnt_q <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) state_q <= WrAckEn ? StWack : StDone;
            end
          end
        end
        StWack: begin
          if (rx_avail) begin
            err_q   <= (rx_head != AckByte);
            state_q <= StDone;
          end
        end
        StRdata: begin
          if (rx_avail) begin
            // First byte ends up in [7:0] after four shifts.
            rd_word_q  <= {rx_head, rd_word_q[31:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) state_q <= StRpush;
          end
        end
        StRpush: begin
          if (bus.rd_data_ready) begin
            cnt_q   <= cnt_q - 8'd1;
            state_q <= (cnt_q == 8'd1) ? StDone : StRdata;
          end
        end
        StDone: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.wr_data_ready = wr_take;
  assign bus.rd_data       = rd_word_q;
  assign bus.rd_data_valid = (state_q == StRpush);
  assign bus.cmd_done      = (state_q == StDone);
  assign bus.cmd_err       = (state_q == StDone) && err_q;
  assign bus.tx_data       = tx_head;
  assign bus.tx_has_data   = tx_avail;
  assign bus.rx_has_space  = rx_space;

endmodule
